// File: rtl/memory_mmio.sv
// RAM with memory-mapped I/O ports at the top of the address space, plus a
// second RAM-only monitor port. Input ports are synchronized and raise irq on change.
module memory_mmio #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned NPORT = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                we,
  input  logic                re,
  input  logic [AW-1:0]       MA,
  input  logic [DW-1:0]       WD,
  output logic [DW-1:0]       RD,
  input  logic                prg_we,
  input  logic [AW-1:0]       prg_MA,
  input  logic [DW-1:0]       prg_WD,
  output logic [DW-1:0]       prg_RD,
  output logic [NPORT*DW-1:0] oport,
  input  logic [NPORT*DW-1:0] iport,
  output logic                irq
);

  localparam int unsigned RAMD = (2 ** AW) - NPORT;
  localparam logic [AW-1:0] RamTop = AW'(RAMD);

  // Port k lives at the all-ones address minus k.
  function automatic logic [AW-1:0] port_addr(input int unsigned k);
    return {AW{1'b1}} - AW'(k);
  endfunction

  logic [DW-1:0] mem [RAMD];

  logic                cpu_ram;
  logic                prg_ram;
  logic [NPORT-1:0]    port_hit;

  logic [DW-1:0]       rd_d;
  logic [DW-1:0]       rd_q;
  logic [DW-1:0]       prg_rd_d;
  logic [DW-1:0]       prg_rd_q;

  logic [NPORT*DW-1:0] oport_d;
  logic [NPORT*DW-1:0] oport_q;
  logic [NPORT*DW-1:0] sync1_q;
  logic [NPORT*DW-1:0] isync_q;
  logic [NPORT*DW-1:0] iprev_q;

  logic [NPORT-1:0]    chg_d;
  logic [NPORT-1:0]    chg_q;
  logic                irq_q;

  assign cpu_ram = (MA < RamTop);
  assign prg_ram = (prg_MA < RamTop);

  always_comb begin
    port_hit = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      port_hit[k] = (MA == port_addr(k));
    end
  end

  // RAM is deliberately not reset; the monitor write is issued last so it
  // wins a same-address collision with the CPU.
  always_ff @(posedge clock) begin
    if (we && cpu_ram) begin
      mem[MA] <= WD;
    end
    if (prg_we && prg_ram) begin
      mem[prg_MA] <= prg_WD;
    end
  end

  always_comb begin
    rd_d = '0;
    if (cpu_ram) begin
      rd_d = mem[MA];
    end
    for (int unsigned k = 0; k < NPORT; k++) begin
      if (port_hit[k]) begin
        rd_d = isync_q[k*DW +: DW];
      end
    end
  end

  always_comb begin
    prg_rd_d = '0;
    if (prg_ram) begin
      prg_rd_d = mem[prg_MA];
    end
  end

  always_comb begin
    oport_d = oport_q;
    for (int unsigned k = 0; k < NPORT; k++) begin
      if (we && port_hit[k]) begin
        oport_d[k*DW +: DW] = WD;
      end
    end
  end

  // A write with re high is a write only; a fresh change beats a clear.
  always_comb begin
    chg_d = chg_q;
    for (int unsigned k = 0; k < NPORT; k++) begin
      if (isync_q[k*DW +: DW] != iprev_q[k*DW +: DW]) begin
        chg_d[k] = 1'b1;
      end else if (re && !we && port_hit[k]) begin
        chg_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q     <= '0;
      prg_rd_q <= '0;
    end else begin
      rd_q     <= rd_d;
      prg_rd_q <= prg_rd_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oport_q <= '0;
      sync1_q <= '0;
      isync_q <= '0;
      iprev_q <= '0;
      chg_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      oport_q <= oport_d;
      sync1_q <= iport;
      isync_q <= sync1_q;
      iprev_q <= isync_q;
      chg_q   <= chg_d;
      irq_q   <= |chg_q;
    end
  end

  assign RD     = rd_q;
  assign prg_RD = prg_rd_q;
  assign oport  = oport_q;
  assign irq    = irq_q;

endmodule
